// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote session controller: state encoding,
// default voter count, majority threshold and ballot popcount.
package vote_pkg;

  localparam int unsigned N_VOTERS_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2,
    SHOW  = 2'd3
  } state_e;

  // Strict majority of n voters (n odd).
  function automatic int unsigned majority_thr(input int unsigned n);
    return (n / 2) + 1;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for one asynchronous button bit with a rising-edge
// pulse; rise_c is combinational from flops and lasts one clock.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/vote_session_ctrl.sv
// One-vote-per-voter majority session controller: IDLE -> OPEN -> TALLY -> SHOW.
// Define VOTE_TIMEOUT_EN to add the OPEN-session timer that forces a tally.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned N_VOTERS       = N_VOTERS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned HOLD_CYCLES    = 300_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            close,
  input  logic [N_VOTERS-1:0]             sw,
  input  logic [N_VOTERS-1:0]             cast,
  output logic [N_VOTERS-1:0]             voted,
  output logic [$clog2(N_VOTERS+1)-1:0]   yes_count,
  output logic                            led,
  output logic                            led_valid,
  output logic                            busy
);

  localparam int unsigned CNT_W  = $clog2(N_VOTERS + 1);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if ((N_VOTERS < 3) || ((N_VOTERS % 2) == 0) || (N_VOTERS > 32) ||
      (HOLD_CYCLES < 1) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("vote_session_ctrl: invalid parameter set");
  end

  // Button conditioning: only synchronized rising edges act.
  logic                start_rise_c;
  logic                close_rise_c;
  logic [N_VOTERS-1:0] cast_rise_c;

  btn_sync_edge u_start_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (start),
    .rise_c (start_rise_c)
  );

  btn_sync_edge u_close_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (close),
    .rise_c (close_rise_c)
  );

  for (genvar g = 0; g < N_VOTERS; g++) begin : g_cast_sync
    btn_sync_edge u_cast_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (cast[g]),
      .rise_c (cast_rise_c[g])
    );
  end

  // Switches share the cast path depth so ballot and cast edge line up.
  logic [N_VOTERS-1:0] sw_meta_q;
  logic [N_VOTERS-1:0] sw_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  state_e              state_q,     state_d;
  logic [N_VOTERS-1:0] ballot_q,    ballot_d;
  logic [N_VOTERS-1:0] voted_q,     voted_d;
  logic [CNT_W-1:0]    yes_q,       yes_d;
  logic                led_q,       led_d;
  logic                led_valid_q, led_valid_d;
  logic                busy_q,      busy_d;
  logic [HOLD_W-1:0]   hold_q,      hold_d;
  logic [N_VOTERS-1:0] accept_c;
  logic                timer_exp_c;
  int unsigned         tally_c;

`ifdef VOTE_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  logic [TMR_W-1:0] timer_q, timer_d;

  assign timer_exp_c = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timer_exp_c = 1'b0;
`endif

  assign accept_c = cast_rise_c & ~voted_q;
  assign tally_c  = popcount(32'(ballot_q & voted_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ballot_q    <= '0;
      voted_q     <= '0;
      yes_q       <= '0;
      led_q       <= 1'b0;
      led_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ballot_q    <= ballot_d;
      voted_q     <= voted_d;
      yes_q       <= yes_d;
      led_q       <= led_d;
      led_valid_q <= led_valid_d;
      busy_q      <= busy_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ballot_d    = ballot_q;
    voted_d     = voted_q;
    yes_d       = yes_q;
    led_d       = led_q;
    hold_d      = hold_q;
    busy_d      = 1'b0;
    led_valid_d = 1'b0;
`ifdef VOTE_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_rise_c) begin
          state_d  = OPEN;
          ballot_d = '0;
          voted_d  = '0;
          yes_d    = '0;
          led_d    = 1'b0;
`ifdef VOTE_TIMEOUT_EN
          timer_d  = '0;
`endif
        end
      end
      OPEN: begin
        // Casts landing with a close or timeout are still accepted.
        ballot_d = (ballot_q & ~accept_c) | (sw_sync_q & accept_c);
        voted_d  = voted_q | accept_c;
`ifdef VOTE_TIMEOUT_EN
        timer_d  = timer_q + TMR_W'(1);
`endif
        if ((&voted_q) || close_rise_c || timer_exp_c) begin
          state_d = TALLY;
        end
      end
      TALLY: begin
        yes_d   = CNT_W'(tally_c);
        led_d   = (tally_c >= majority_thr(N_VOTERS));
        hold_d  = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == OPEN) || (state_d == TALLY);
    led_valid_d = (state_d == SHOW);
  end

  assign voted     = voted_q;
  assign yes_count = yes_q;
  assign led       = led_q;
  assign led_valid = led_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: vector table, timing corner
// sequences and randomized sessions against a ballot-level model.
module tb_vote_session_ctrl;

  localparam int unsigned NV      = 5;
  localparam int unsigned HOLD    = 6;
  localparam int unsigned TIMEOUT = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          close;
  logic [NV-1:0] sw;
  logic [NV-1:0] cast;
  logic [NV-1:0] voted;
  logic [2:0]    yes_count;
  logic          led;
  logic          led_valid;
  logic          busy;

  int total = 0;
  int bad   = 0;

  vote_session_ctrl #(
    .N_VOTERS       (NV),
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .close     (close),
    .sw        (sw),
    .cast      (cast),
    .voted     (voted),
    .yes_count (yes_count),
    .led       (led),
    .led_valid (led_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV-1:0] swv;
    logic [NV-1:0] mask;
    logic [NV-1:0] exp_voted;
    logic [2:0]    exp_yes;
    logic          exp_led;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("open_busy", 32'(busy), 32'd1);
  endtask

  task automatic cast_event(input logic [NV-1:0] mask, input logic [NV-1:0] swv);
    sw   = swv;
    cast = mask;
    tick();
    cast = '0;
    repeat (2) tick();
  endtask

  task automatic press_close();
    close = 1'b1;
    tick();
    close = 1'b0;
    tick();
  endtask

  // Wait for the result, check it, and check the display lasts HOLD cycles.
  task automatic finish_session(input string nm, input logic [NV-1:0] ev,
                                input logic [2:0] ey, input logic el);
    int n;
    n = 0;
    while (!led_valid && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_show_reached"}, 32'(led_valid), 32'd1);
    chk({nm, "_voted"}, 32'(voted), 32'(ev));
    chk({nm, "_yes"}, 32'(yes_count), 32'(ey));
    chk({nm, "_led"}, 32'(led), 32'(el));
    n = 0;
    while (led_valid && n < int'(HOLD) + 10) begin
      tick();
      n++;
    end
    chk({nm, "_hold_len"}, 32'(n), 32'(HOLD));
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_idle_led_kept"}, 32'(led), 32'(el));
  endtask

  function automatic int unsigned ones(input logic [NV-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(NV); i++) if (v[i]) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NV-1:0] mv, mb, msk, swv;
    int            nev;

    rst_n = 1'b0;
    start = 1'b0;
    close = 1'b0;
    sw    = '0;
    cast  = '0;

    vecs[0] = '{5'b10110, 5'b11111, 5'b11111, 3'd3, 1'b1};
    vecs[1] = '{5'b00011, 5'b00011, 5'b00011, 3'd2, 1'b0};
    vecs[2] = '{5'b11111, 5'b11111, 5'b11111, 3'd5, 1'b1};
    vecs[3] = '{5'b00000, 5'b11111, 5'b11111, 3'd0, 1'b0};
    vecs[4] = '{5'b11111, 5'b00111, 5'b00111, 3'd3, 1'b1};
    vecs[5] = '{5'b01101, 5'b00000, 5'b00000, 3'd0, 1'b0};
    vecs[6] = '{5'b11000, 5'b11011, 5'b11011, 3'd2, 1'b0};

    repeat (3) tick();
    chk("rst_voted", 32'(voted), 32'd0);
    chk("rst_yes", 32'(yes_count), 32'd0);
    chk("rst_led_valid", 32'(led_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_led", 32'(led), 32'd0);

    // Table: voters in mask cast one at a time; partial sessions are closed.
    for (int v = 0; v < 7; v++) begin
      open_session();
      for (int i = 0; i < int'(NV); i++) begin
        if (vecs[v].mask[i]) cast_event(NV'(1) << i, vecs[v].swv);
      end
      if (vecs[v].mask != '1) press_close();
      finish_session($sformatf("vec%0d", v), vecs[v].exp_voted, vecs[v].exp_yes,
                     vecs[v].exp_led);
    end

    // Revote attempt: second cast with sw flipped is ignored.
    open_session();
    cast_event(5'b00100, 5'b00100);
    cast_event(5'b00100, 5'b00000);
    chk("revote_voted", 32'(voted), 32'b00100);
    press_close();
    finish_session("revote", 5'b00100, 3'd1, 1'b0);

    // Final-cast latency: voted at 3rd edge, SHOW two edges later.
    open_session();
    for (int i = 0; i < 4; i++) cast_event(NV'(1) << i, 5'b11001);
    sw   = 5'b11001;
    cast = 5'b10000;
    tick();
    cast = '0;
    tick();
    chk("lat_voted_early", 32'(voted), 32'b01111);
    tick();
    chk("lat_voted", 32'(voted), 32'b11111);
    tick();
    chk("lat_tally_busy", 32'(busy), 32'd1);
    chk("lat_tally_no_show", 32'(led_valid), 32'd0);
    tick();
    chk("lat_show", 32'(led_valid), 32'd1);
    finish_session("lat", 5'b11111, 3'd3, 1'b1);

    // Last cast and close edge in the same cycle.
    open_session();
    for (int i = 0; i < 4; i++) cast_event(NV'(1) << i, 5'b01111);
    sw    = 5'b11111;
    cast  = 5'b10000;
    close = 1'b1;
    tick();
    cast  = '0;
    close = 1'b0;
    tick();
    finish_session("cast_close", 5'b11111, 3'd5, 1'b1);
    repeat (8) tick();
    chk("cast_close_single_tally", 32'({busy, led_valid}), 32'd0);

    // Timeout session: start at n0, OPEN at n3, SHOW visible at n24 with macro.
    start = 1'b1;
`ifdef VOTE_TIMEOUT_EN
    for (int i = 1; i <= 24; i++) begin
`else
    for (int i = 1; i <= 60; i++) begin
`endif
      tick();
      case (i)
        1: start = 1'b0;
        3: begin sw = 5'b00111; cast = 5'b00111; end
        4: cast = '0;
`ifdef VOTE_TIMEOUT_EN
        23: begin
          chk("to_before_show", 32'(led_valid), 32'd0);
          chk("to_busy", 32'(busy), 32'd1);
        end
        24: chk("to_show", 32'(led_valid), 32'd1);
`else
        24, 60: begin
          chk("no_to_still_open", 32'(busy), 32'd1);
          chk("no_to_no_show", 32'(led_valid), 32'd0);
        end
`endif
        default: ;
      endcase
    end
`ifndef VOTE_TIMEOUT_EN
    press_close();
`endif
    finish_session("timeout", 5'b00111, 3'd3, 1'b1);

    // Reset mid-OPEN clears outputs at once; a held start gives one session.
    open_session();
    cast_event(5'b00111, 5'b00101);
    chk("mid_rst_pre_voted", 32'(voted), 32'b00111);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({voted, yes_count, led, led_valid, busy}), 32'd0);
    start = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("held_start_open", 32'(busy), 32'd1);
    chk("held_start_clean", 32'(voted), 32'd0);
    start = 1'b0;
    cast_event(5'b11111, 5'b01110);
    finish_session("post_rst", 5'b11111, 3'd3, 1'b1);

    // Random sessions against a first-cast-wins ballot model.
    for (int s = 0; s < 12; s++) begin
      mv  = '0;
      mb  = '0;
      nev = int'($urandom_range(1, 5));
      open_session();
      for (int e = 0; e < nev; e++) begin
        if (mv == '1) break;
        msk = NV'($urandom_range(0, 31));
        swv = NV'($urandom_range(0, 31));
        for (int i = 0; i < int'(NV); i++) begin
          if (msk[i] && !mv[i]) begin
            mv[i] = 1'b1;
            mb[i] = swv[i];
          end
        end
        cast_event(msk, swv);
      end
      if (mv != '1) press_close();
      finish_session($sformatf("rnd%0d", s), mv, 3'(ones(mb & mv)),
                     (ones(mb & mv) >= (NV / 2 + 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Session controller for the 5-voter majority vote on the lab board. Sequences a vote: opens a session on a start button, latches each voter's switch value when that voter presses their cast button, then closes the session. It tallies the ballots against the majority threshold and holds the result on the LED for a fixed display time. It sits between the board buttons/switches and the result LEDs, replacing direct switch-to-LED majority with a clocked, one-vote-per-voter session.

## Interface
- N_VOTERS, 5, number of voters; must be odd, ≥3.
- TIMEOUT_CYCLES, 500_000_000, session length limit in clocks (timeout feature only).
- HOLD_CYCLES, 300_000_000, clocks the result is displayed.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- start  in  1  start-session button, asynchronous, level.
- close  in  1  early-close button, asynchronous, level.
- sw  in  N_VOTERS  ballot switches, 1 = yes; sampled only at cast.
- cast  in  N_VOTERS  per-voter cast buttons, asynchronous, level.
- voted  out  N_VOTERS  per-voter "ballot accepted" LEDs.
- yes_count  out  $clog2(N_VOTERS+1)  registered yes tally.
- led  out  1  majority result; 1 = passed.
- led_valid  out  1  high while the result is displayed.
- busy  out  1  high in OPEN or TALLY.

## Operation
- Every button input (start, close, each cast bit) passes through a 2-FF synchronizer and a rising-edge detector. Only edges act. Holding a button counts once.
- States are IDLE, OPEN, TALLY and SHOW.
- IDLE: start edge → OPEN. On entry to OPEN, ballot, voted and timer are cleared.
- OPEN, cast edge on voter i with voted[i]=0: ballot[i] ← synchronized sw[i]; voted[i] ← 1.
- OPEN, cast edge on voter i with voted[i]=1: ignored. No revoting.
- OPEN exits to TALLY on any of:
  - all voted bits set;
  - close edge;
  - timer expiry (when the timeout feature is compiled in).
- TALLY lasts one cycle. yes_count ← popcount(ballot & voted). led ← (yes_count ≥ N_VOTERS/2+1). A missing vote counts as no. Next state is SHOW.
- SHOW: led_valid=1. led, yes_count and voted are held. After HOLD_CYCLES clocks → IDLE.
- Edges on start, close and cast outside their valid states are ignored.
- IDLE keeps the last led, yes_count and voted values visible with led_valid=0. They are cleared on the next OPEN entry.

## Timing
- Reset values: state IDLE; voted=0, yes_count=0, led=0, led_valid=0, busy=0; timer and hold counter 0.
- Input-to-action latency: an input rising before clock edge k takes effect at edge k+2.
  - Example: voted[i] is visible after the 3rd edge following the cast rise.
- Final cast accepted at edge e gives state TALLY after e+1 and SHOW after e+2. yes_count, led and led_valid update together at e+2.
- SHOW lasts exactly HOLD_CYCLES cycles.
- Simultaneous events in OPEN:
  - cast edges and a close or timeout in the same cycle: the casts are accepted and counted.
  - several voters casting in the same cycle: all accepted.
- Timer counts OPEN cycles. Expiry is the cycle the count reaches TIMEOUT_CYCLES−1. Exit to TALLY occurs on the following edge.
- Reset asserted mid-session returns the block to reset values immediately. Synchronizer flops also reset to 0, so a button held through reset release produces one edge.

## Configuration
- VOTE_TIMEOUT_EN defined: the OPEN timer exists, and expiry closes the session.
- VOTE_TIMEOUT_EN undefined: no timer logic, and TIMEOUT_CYCLES is unused. OPEN exits only on all-voted or close.

## Structure
- Shared package vote_pkg holds:
  - the state enum (IDLE, OPEN, TALLY, SHOW);
  - the default N_VOTERS;
  - the majority threshold function (n/2+1);
  - the popcount function.
- One sub-module: btn_sync_edge (2-FF synchronizer plus rising-edge pulse, active-low async reset). It is instantiated per button bit.

## Test plan
- Reset, then start, then all five cast with sw=5'b10110 → voted=5'b11111, yes_count=3, led=1, led_valid=1 for HOLD_CYCLES, then IDLE.
- Start, voters 0 and 1 cast with sw=5'b00011, then close → yes_count=2, led=0. Missing votes count as no.
- Voter 2 casts yes, sets sw[2]=0, casts again → ballot stays yes, voted[2] pulses nothing new, yes_count includes voter 2.
- VOTE_TIMEOUT_EN with TIMEOUT_CYCLES=20: start, 3 yes casts, no close → TALLY exactly 20 cycles after OPEN entry, led=1. Without the macro, the block stays in OPEN indefinitely.
- Last cast and close edge in the same cycle → cast counted, single TALLY, yes_count correct.
- rst_n asserted mid-OPEN with voted=5'b00111 → all outputs 0 asynchronously. After release, the first start edge opens a clean session.
